i2c_slave_regs: RTL and testbench

I2C slave that owns the four 8-bit control registers `slv_reg0`..`slv_reg3` and drives them into the FND display stage (`FND_C`) and the rest of the SLAVE design. It oversamples SCL/SDA on the system clock and decodes START/STOP and 7-bit addressing. It supports pointer-addressed burst writes and reads with auto-increment, and drives SDA open-drain for ACK and read data.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_line_filter.sv | 55 +++++
 rtl/i2c_slave_regs.sv | 156 +++++++++++++++
 tb/tb_i2c_slave_regs.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and sizing for the I2C register slave.
package i2c_pkg;

    localparam int REG_COUNT = 4;
    localparam int PTR_W = 2;
    localparam logic [6:0] DEF_SLAVE_ADDR = 7'h5A;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RACK,
        ST_IGNORE
    } i2c_state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronises and deglitches SCL/SDA, then flags SCL edges and START/STOP.
// Filtered levels lag the pads by 2 + FILT_LEN clocks; no flow control.
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda_i,
    output logic sda_f,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0]          scl_sync, sda_sync;
    logic [FILT_LEN-2:0] scl_hist, sda_hist;
    logic                scl_f, scl_prev, sda_prev;
    logic [FILT_LEN-1:0] scl_win, sda_win;

    // The newest synchronised sample plus the history form the stability window.
    assign scl_win = {scl_hist, scl_sync[1]};
    assign sda_win = {sda_hist, sda_sync[1]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= '1;
            sda_hist <= '1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda_i};
            scl_hist <= scl_win[FILT_LEN-2:0];
            sda_hist <= sda_win[FILT_LEN-2:0];
            if (&scl_win)       scl_f <= 1'b1;
            else if (~|scl_win) scl_f <= 1'b0;
            if (&sda_win)       sda_f <= 1'b1;
            else if (~|sda_win) sda_f <= 1'b0;
            scl_prev <= scl_f;
            sda_prev <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_prev;
    assign scl_fall  = ~scl_f & scl_prev;
    assign start_det = scl_f & scl_prev & sda_prev & ~sda_f;
    assign stop_det  = scl_f & scl_prev & ~sda_prev & sda_f;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave owning four 8-bit registers with pointer-addressed burst read/write.
// Writes commit one clock after the 8th SCL rise; the bus master is held off only by ACK/NACK.
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
    parameter int         FILT_LEN   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] slv_reg0,
    output logic [7:0] slv_reg1,
    output logic [7:0] slv_reg2,
    output logic [7:0] slv_reg3,
    output logic       wr_strobe,
    output logic [1:0] wr_index
);

    logic sda_f, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_filt (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda_i     (sda_i),
        .sda_f     (sda_f),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_t       state;
    logic [7:0]       regs [REG_COUNT];
    logic [PTR_W-1:0] ptr, ptr_nxt;
    logic [6:0]       sr, tx;
    logic [2:0]       bit_cnt;
    logic [7:0]       byte_in;
    logic             rw, ack_on;

    assign byte_in = {sr, sda_f};
    assign ptr_nxt = ptr + 2'd1;

    assign slv_reg0 = regs[0];
    assign slv_reg1 = regs[1];
    assign slv_reg2 = regs[2];
    assign slv_reg3 = regs[3];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= 8'h00;
            ptr       <= '0;
            sr        <= '0;
            tx        <= '0;
            bit_cnt   <= '0;
            rw        <= 1'b0;
            ack_on    <= 1'b0;
            sda_oe    <= 1'b0;
            wr_strobe <= 1'b0;
            wr_index  <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (stop_det) begin
                state   <= ST_IDLE;
                sda_oe  <= 1'b0;
                ack_on  <= 1'b0;
                bit_cnt <= '0;
            end else if (start_det) begin
                state   <= ST_ADDR;
                sda_oe  <= 1'b0;
                ack_on  <= 1'b0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    ST_ADDR, ST_PTR, ST_WDATA: begin
                        if (scl_rise) begin
                            sr      <= byte_in[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (state == ST_ADDR) begin
                                    rw    <= byte_in[0];
                                    state <= (byte_in[7:1] == SLAVE_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                                end else if (state == ST_PTR) begin
                                    if (byte_in < 8'(REG_COUNT)) begin
                                        ptr   <= byte_in[PTR_W-1:0];
                                        state <= ST_PTR_ACK;
                                    end else begin
                                        state <= ST_IGNORE;
                                    end
                                end else begin
                                    regs[ptr] <= byte_in;
                                    wr_strobe <= 1'b1;
                                    wr_index  <= ptr;
                                    ptr       <= ptr_nxt;
                                    state     <= ST_WDATA_ACK;
                                end
                            end
                        end
                    end
                    // First SCL fall opens the ACK slot, the second closes it.
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!ack_on) begin
                                ack_on <= 1'b1;
                                sda_oe <= 1'b1;
                            end else begin
                                ack_on  <= 1'b0;
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                if (state != ST_ADDR_ACK) begin
                                    state <= ST_WDATA;
                                end else if (rw) begin
                                    tx     <= regs[ptr][6:0];
                                    sda_oe <= ~regs[ptr][7];
                                    state  <= ST_RDATA;
                                end else begin
                                    state <= ST_PTR;
                                end
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 3'd0) begin
                                sda_oe <= 1'b0;
                                state  <= ST_RACK;
                            end else begin
                                sda_oe <= ~tx[6];
                                tx     <= {tx[5:0], 1'b0};
                            end
                        end
                    end
                    ST_RACK: begin
                        if (scl_rise && sda_f) begin
                            state <= ST_IGNORE;
                        end else if (scl_fall) begin
                            ptr     <= ptr_nxt;
                            tx      <= regs[ptr_nxt][6:0];
                            sda_oe  <= ~regs[ptr_nxt][7];
                            bit_cnt <= '0;
                            state   <= ST_RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bit-banged I2C master plus table-driven single writes.
module tb_i2c_slave_regs;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe, wr_strobe;
    logic [7:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;
    logic [1:0] wr_index;

    int total = 0;
    int bad = 0;
    int strb_cnt = 0;
    logic oe_seen = 1'b0;
    logic [1:0] idx_q[$];

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_regs dut (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda_i     (sda_line),
        .sda_oe    (sda_oe),
        .slv_reg0  (slv_reg0),
        .slv_reg1  (slv_reg1),
        .slv_reg2  (slv_reg2),
        .slv_reg3  (slv_reg3),
        .wr_strobe (wr_strobe),
        .wr_index  (wr_index)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            strb_cnt++;
            idx_q.push_back(wr_index);
        end
        if (sda_oe === 1'b1) oe_seen = 1'b1;
    end

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  ptr;
        logic [7:0]  dat;
        logic        aack;
        logic        pack;
        logic        dack;
        int          strb;
        logic [31:0] regs;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] regs_now();
        return {slv_reg3, slv_reg2, slv_reg1, slv_reg0};
    endfunction

    task automatic bit_xfer(input logic b, input bit glitch, output logic smp);
        scl = 1'b0;
        cyc(10);
        sda_m = b;
        cyc(10);
        scl = 1'b1;
        cyc(8);
        smp = sda_line;
        if (glitch) begin
            cyc(3);
            scl = 1'b0;
            cyc(2);
            scl = 1'b1;
            cyc(7);
        end else begin
            cyc(12);
        end
    endtask

    task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], i == glitch_bit, s);
        bit_xfer(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, 1'b0, s);
            d[i] = s;
        end
        bit_xfer(~mack, 1'b0, s);
    endtask

    task automatic i2c_start();
        sda_m = 1'b0;
        cyc(10);
    endtask

    task automatic i2c_rstart();
        scl = 1'b0;
        cyc(10);
        sda_m = 1'b1;
        cyc(10);
        scl = 1'b1;
        cyc(10);
        sda_m = 1'b0;
        cyc(10);
    endtask

    task automatic i2c_stop();
        scl = 1'b0;
        cyc(10);
        sda_m = 1'b0;
        cyc(10);
        scl = 1'b1;
        cyc(10);
        sda_m = 1'b1;
        cyc(20);
    endtask

    initial begin
        logic       a0, a1, a2, a3, a4, a5, a6;
        logic [7:0] rd0, rd1;
        logic [7:0] idxv;
        logic       s;

        //          addr   ptr    dat    aack  pack  dack  strb regs {r3,r2,r1,r0}
        vt[0] = '{8'hA0, 8'h02, 8'h5C, 1'b0, 1'b0, 1'b0, 0, 32'hAA2211BB};
        vt[1] = '{8'hB4, 8'h02, 8'h5C, 1'b1, 1'b1, 1'b1, 1, 32'hAA5C11BB};
        vt[2] = '{8'hB4, 8'h07, 8'h99, 1'b1, 1'b0, 1'b0, 0, 32'hAA5C11BB};
        vt[3] = '{8'hB4, 8'h00, 8'h01, 1'b1, 1'b1, 1'b1, 1, 32'hAA5C1101};
        vt[4] = '{8'hB4, 8'h04, 8'h00, 1'b1, 1'b0, 1'b0, 0, 32'hAA5C1101};
        vt[5] = '{8'hB4, 8'h03, 8'hFE, 1'b1, 1'b1, 1'b1, 1, 32'hFE5C1101};

        cyc(4);
        chk("reset_regs", regs_now(), 32'h0);
        chk("reset_oe", {31'b0, sda_oe}, 32'h0);
        chk("reset_strobe", {31'b0, wr_strobe}, 32'h0);
        chk("reset_index", {30'b0, wr_index}, 32'h0);
        reset = 1'b1;
        cyc(20);

        // Burst write starting at register 1.
        strb_cnt = 0;
        idx_q.delete();
        i2c_start();
        write_byte(8'hB4, -1, a0);
        write_byte(8'h01, -1, a1);
        write_byte(8'h11, -1, a2);
        write_byte(8'h22, -1, a3);
        write_byte(8'h33, -1, a4);
        i2c_stop();
        chk("burst_acks", {27'b0, a0, a1, a2, a3, a4}, 32'h1F);
        chk("burst_strobes", strb_cnt, 3);
        idxv = 8'h0;
        for (int i = 0; i < idx_q.size() && i < 3; i++) idxv = {idxv[5:0], idx_q[i]};
        chk("burst_index", {24'b0, idxv}, {24'b0, 8'b00_01_10_11});
        chk("burst_regs", regs_now(), 32'h33221100);

        // Pointer wrap, then set pointer to 0 and read back two bytes.
        strb_cnt = 0;
        i2c_start();
        write_byte(8'hB4, -1, a0);
        write_byte(8'h03, -1, a1);
        write_byte(8'hAA, -1, a2);
        write_byte(8'hBB, -1, a3);
        i2c_rstart();
        write_byte(8'hB4, -1, a4);
        write_byte(8'h00, -1, a5);
        i2c_rstart();
        write_byte(8'hB5, -1, a6);
        read_byte(1'b1, rd0);
        read_byte(1'b0, rd1);
        i2c_stop();
        chk("wrap_acks", {25'b0, a0, a1, a2, a3, a4, a5, a6}, 32'h7F);
        chk("wrap_regs", regs_now(), 32'hAA2211BB);
        chk("wrap_strobes", strb_cnt, 2);
        chk("read_byte0", {24'b0, rd0}, 32'hBB);
        chk("read_byte1", {24'b0, rd1}, 32'h11);

        // Foreign address followed by filler bytes: the slave must stay off the bus.
        oe_seen = 1'b0;
        i2c_start();
        write_byte(8'hA0, -1, a0);
        write_byte(8'hFF, -1, a1);
        write_byte(8'hFF, -1, a2);
        i2c_stop();
        chk("mismatch_oe", {31'b0, oe_seen}, 32'h0);
        chk("mismatch_regs", regs_now(), 32'hAA2211BB);

        for (int v = 0; v < 6; v++) begin
            strb_cnt = 0;
            i2c_start();
            write_byte(vt[v].addr, -1, a0);
            write_byte(vt[v].ptr, -1, a1);
            write_byte(vt[v].dat, -1, a2);
            i2c_stop();
            chk($sformatf("vec%0d_aack", v), {31'b0, a0}, {31'b0, vt[v].aack});
            chk($sformatf("vec%0d_pack", v), {31'b0, a1}, {31'b0, vt[v].pack});
            chk($sformatf("vec%0d_dack", v), {31'b0, a2}, {31'b0, vt[v].dack});
            chk($sformatf("vec%0d_strb", v), strb_cnt, vt[v].strb);
            chk($sformatf("vec%0d_regs", v), regs_now(), vt[v].regs);
        end

        // STOP after four data bits: nothing written, pointer stays at 1.
        strb_cnt = 0;
        i2c_start();
        write_byte(8'hB4, -1, a0);
        write_byte(8'h01, -1, a1);
        for (int i = 0; i < 4; i++) bit_xfer(1'b1, 1'b0, s);
        i2c_stop();
        chk("abort_strobes", strb_cnt, 0);
        chk("abort_regs", regs_now(), 32'hFE5C1101);
        i2c_start();
        write_byte(8'hB5, -1, a2);
        read_byte(1'b0, rd0);
        i2c_stop();
        chk("abort_read_ack", {31'b0, a2}, 32'h1);
        chk("abort_read", {24'b0, rd0}, 32'h11);

        // Two-clock low glitch on SCL during a data bit must not add a bit.
        strb_cnt = 0;
        i2c_start();
        write_byte(8'hB4, -1, a0);
        write_byte(8'h01, -1, a1);
        write_byte(8'h6D, 3, a2);
        i2c_stop();
        chk("glitch_ack", {31'b0, a2}, 32'h1);
        chk("glitch_strobes", strb_cnt, 1);
        chk("glitch_regs", regs_now(), 32'hFE5C6D01);

        // Reset while the slave is driving the ACK for a data byte.
        i2c_start();
        write_byte(8'hB4, -1, a0);
        write_byte(8'h02, -1, a1);
        for (int i = 7; i >= 0; i--) bit_xfer(1'(8'h77 >> i), 1'b0, s);
        scl = 1'b0;
        cyc(12);
        chk("midack_oe", {31'b0, sda_oe}, 32'h1);
        chk("midack_regs", regs_now(), 32'hFE776D01);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_oe", {31'b0, sda_oe}, 32'h0);
        chk("rst_regs", regs_now(), 32'h0);
        chk("rst_strobe", {31'b0, wr_strobe}, 32'h0);
        chk("rst_index", {30'b0, wr_index}, 32'h0);
        cyc(2);
        scl = 1'b1;
        sda_m = 1'b1;
        reset = 1'b1;
        cyc(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
